// File: rtl/hpm_overflow_ctrl_pkg.sv
// Shared constants and types for the HPM counter-overflow (Sscofpmf) control block.
// Holds CSR addresses, state-bit positions and the core configuration type.
package hpm_overflow_ctrl_pkg;

  typedef struct packed {
    int unsigned XLEN;
  } cfg_t;

  localparam cfg_t cva6_cfg_empty = '{XLEN: 64};

  // Positions inside the 4-bit nibble held in mhpmevent[XLEN-1:XLEN-4]
  localparam int unsigned OF_BIT   = 3;
  localparam int unsigned MINH_BIT = 2;
  localparam int unsigned SINH_BIT = 1;
  localparam int unsigned UINH_BIT = 0;

  localparam logic [11:0] CSR_MHPM_EVENT_3  = 12'h323;
  localparam logic [11:0] CSR_MHPM_EVENT_3H = 12'h723;
  localparam logic [11:0] CSR_SCOUNTOVF     = 12'hDA0;
  localparam int unsigned IRQ_LCOFI         = 13;

  typedef enum logic [1:0] {
    PRIV_U = 2'b00,
    PRIV_S = 2'b01,
    PRIV_M = 2'b11
  } priv_lvl_t;

  typedef enum logic {
    ARMED      = 1'b0,
    OVERFLOWED = 1'b1
  } ovf_state_t;

  // RV32 keeps the state bits in the high-half event CSRs
  function automatic logic [11:0] evt_addr(input int unsigned xlen, input int unsigned idx);
    return ((xlen == 32) ? CSR_MHPM_EVENT_3H : CSR_MHPM_EVENT_3) + idx[11:0];
  endfunction

endpackage

// File: rtl/hpm_ovf_slot.sv
// One counter's overflow/inhibit state: OF state machine, mode-inhibit bits,
// wrap detection and the combinational inhibit output.
module hpm_ovf_slot
  import hpm_overflow_ctrl_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        debug_mode_i,
  input  logic [1:0]  priv_lvl_i,
  input  logic        inc_i,
  input  logic [63:0] val_i,
  input  logic        cnt_wr_i,
  input  logic        csr_we_i,
  input  logic [3:0]  csr_wdata_i,
  output logic [3:0]  state_o,
  output logic        of_nxt_o,
  output logic        inhibit_o
);

  ovf_state_t r_ovf, w_ovf_d;
  logic [2:0] r_inh, w_inh_d;
  logic       w_wrap;

  // A software-written all-ones value is not a wrap; only a real increment is
  assign w_wrap = inc_i && (&val_i) && !cnt_wr_i && !debug_mode_i;

  always_comb begin
    w_ovf_d = r_ovf;
    w_inh_d = r_inh;
    if (w_wrap) w_ovf_d = OVERFLOWED;
    if (csr_we_i) begin
      w_ovf_d = ovf_state_t'(csr_wdata_i[OF_BIT]);
      w_inh_d = csr_wdata_i[2:0];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ovf <= ARMED;
      r_inh <= '0;
    end else begin
      r_ovf <= w_ovf_d;
      r_inh <= w_inh_d;
    end
  end

  assign state_o   = {r_ovf == OVERFLOWED, r_inh};
  assign of_nxt_o  = (w_ovf_d == OVERFLOWED);
  assign inhibit_o = (r_inh[MINH_BIT] && priv_lvl_i == PRIV_M) ||
                     (r_inh[SINH_BIT] && priv_lvl_i == PRIV_S) ||
                     (r_inh[UINH_BIT] && priv_lvl_i == PRIV_U);

endmodule

// File: rtl/hpm_overflow_ctrl.sv
// Counter-overflow control: per-counter OF/xINH state, CSR read/write of the
// event high bits and scountovf, and the local counter-overflow interrupt.
module hpm_overflow_ctrl
  import hpm_overflow_ctrl_pkg::*;
#(
  parameter cfg_t        CVA6Cfg    = cva6_cfg_empty,
  parameter int unsigned NrCounters = 6
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               debug_mode_i,
  input  logic [1:0]                         priv_lvl_i,
  input  logic [11:0]                        addr_i,
  input  logic                               we_i,
  input  logic [CVA6Cfg.XLEN-1:0]            data_i,
  output logic [CVA6Cfg.XLEN-1:0]            data_o,
  input  logic [NrCounters-1:0]              cnt_inc_i,
  input  logic [NrCounters-1:0][63:0]        cnt_val_i,
  input  logic [NrCounters-1:0]              cnt_wr_i,
  output logic [NrCounters-1:0]              inhibit_o,
  output logic                               lcofi_o
);

  localparam int unsigned XLEN = CVA6Cfg.XLEN;

  logic [NrCounters-1:0][3:0] w_state;
  logic [NrCounters-1:0]      w_of, w_of_d, w_csr_we;
  logic [XLEN-1:0]            w_rdata, r_data;
  logic                       r_lcofi;
  logic                       w_unused;

  assign w_unused = ^data_i[XLEN-5:0];

  for (genvar g = 0; g < NrCounters; g++) begin : g_slot
    assign w_csr_we[g] = we_i && (addr_i == evt_addr(XLEN, g));
    assign w_of[g]     = w_state[g][OF_BIT];

    hpm_ovf_slot u_slot (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .debug_mode_i (debug_mode_i),
      .priv_lvl_i   (priv_lvl_i),
      .inc_i        (cnt_inc_i[g]),
      .val_i        (cnt_val_i[g]),
      .cnt_wr_i     (cnt_wr_i[g]),
      .csr_we_i     (w_csr_we[g]),
      .csr_wdata_i  (data_i[XLEN-1 -: 4]),
      .state_o      (w_state[g]),
      .of_nxt_o     (w_of_d[g]),
      .inhibit_o    (inhibit_o[g])
    );
  end

  always_comb begin
    w_rdata = '0;
    for (int unsigned i = 0; i < NrCounters; i++)
      if (addr_i == evt_addr(XLEN, i)) w_rdata[XLEN-1 -: 4] = w_state[i];
    if (addr_i == CSR_SCOUNTOVF) w_rdata[NrCounters+2:3] = w_of;
  end

  // Interrupt tracks the next OF value so it moves on the same edge as OF
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_data  <= '0;
      r_lcofi <= 1'b0;
    end else begin
      r_data  <= w_rdata;
      r_lcofi <= |w_of_d;
    end
  end

  assign data_o  = r_data;
  assign lcofi_o = r_lcofi;

endmodule

// File: tb/tb_hpm_overflow_ctrl.sv
// Randomized + directed bench for hpm_overflow_ctrl (RV64, 6 counters) against
// a behavioural model of the overflow/inhibit rules.
module tb_hpm_overflow_ctrl;

  localparam int N = 6;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              dbg;
  logic [1:0]        priv;
  logic [11:0]       addr;
  logic              we;
  logic [63:0]       wdata;
  logic [63:0]       rdata;
  logic [N-1:0]      inc;
  logic [N-1:0][63:0] val;
  logic [N-1:0]      cwr;
  logic [N-1:0]      inh;
  logic              lcofi;

  int total = 0;
  int bad   = 0;

  bit        m_of[N], m_minh[N], m_sinh[N], m_uinh[N];
  bit [63:0] m_data;
  bit        m_lcofi;

  always #5 clk = ~clk;

  hpm_overflow_ctrl #(.NrCounters(N)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .debug_mode_i (dbg),
    .priv_lvl_i   (priv),
    .addr_i       (addr),
    .we_i         (we),
    .data_i       (wdata),
    .data_o       (rdata),
    .cnt_inc_i    (inc),
    .cnt_val_i    (val),
    .cnt_wr_i     (cwr),
    .inhibit_o    (inh),
    .lcofi_o      (lcofi)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit [N-1:0] exp_inhibit(input bit [1:0] p);
    bit [N-1:0] r = '0;
    for (int i = 0; i < N; i++)
      r[i] = (m_minh[i] && p == 2'd3) || (m_sinh[i] && p == 2'd1) || (m_uinh[i] && p == 2'd0);
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_of[i] = 0; m_minh[i] = 0; m_sinh[i] = 0; m_uinh[i] = 0;
    end
    m_data  = '0;
    m_lcofi = 0;
  endtask

  // Applies the rules for one rising edge using the inputs present at that edge
  task automatic model_update();
    bit [63:0] rd = '0;
    bit [3:0]  nib;
    bit        any = 0;
    for (int i = 0; i < N; i++) begin
      if (addr == 12'h323 + 12'(i)) begin
        nib = {m_of[i], m_minh[i], m_sinh[i], m_uinh[i]};
        rd  = 64'(nib) << 60;
      end
      if (addr == 12'hDA0 && m_of[i]) rd = rd + (64'd1 << (i + 3));
    end
    for (int i = 0; i < N; i++) begin
      if (inc[i] && val[i] == {64{1'b1}} && !cwr[i] && !dbg) m_of[i] = 1;
      if (we && addr == 12'h323 + 12'(i)) begin
        m_of[i]   = wdata[63];
        m_minh[i] = wdata[62];
        m_sinh[i] = wdata[61];
        m_uinh[i] = wdata[60];
      end
      any = any | m_of[i];
    end
    m_data  = rd;
    m_lcofi = any;
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle();
    we = 0; inc = '0; cwr = '0; dbg = 0; addr = 12'h000; wdata = '0;
  endtask

  always @(negedge clk) begin
    check("cmp_data",  rdata, m_data);
    check("cmp_lcofi", 64'(lcofi), 64'(m_lcofi));
    check("cmp_inh",   64'(inh), 64'(exp_inhibit(priv)));
  end

  initial begin
    int r;
    rst_n = 0; priv = 2'd3; val = '0;
    idle();
    model_reset();
    #3;
    check("rst_data",  rdata, 64'h0);
    check("rst_lcofi", 64'(lcofi), 64'h0);
    check("rst_inh",   64'(inh), 64'h0);
    @(posedge clk); #3;
    rst_n = 1;

    // wrap on counter 0
    inc[0] = 1; val[0] = '1; addr = 12'hDA0;
    tick();
    check("wrap_lcofi", 64'(lcofi), 64'h1);
    inc = '0;
    tick();
    check("wrap_scountovf", rdata, 64'h8);
    we = 1; addr = 12'h323; wdata = '0;
    tick();
    we = 0;
    check("clear_lcofi", 64'(lcofi), 64'h0);

    // suppressed wraps: debug mode and software counter write
    dbg = 1; inc[0] = 1;
    tick();
    check("dbg_lcofi", 64'(lcofi), 64'h0);
    dbg = 0; cwr[0] = 1;
    tick();
    check("cwr_lcofi", 64'(lcofi), 64'h0);
    inc = '0; cwr = '0; addr = 12'hDA0;
    tick();
    check("suppr_scountovf", rdata, 64'h0);

    // software clear beats hardware set on counter 2
    inc[2] = 1; val[2] = '1; we = 1; addr = 12'h325; wdata = '0;
    tick();
    inc = '0; we = 0;
    tick();
    check("swwin_evt5", rdata, 64'h0);
    check("swwin_lcofi", 64'(lcofi), 64'h0);

    // MINH on counter 1
    we = 1; addr = 12'h324; wdata = 64'h4000_0000_0000_0000; priv = 2'd3;
    tick();
    we = 0;
    check("minh_m", 64'(inh), 64'h2);
    priv = 2'd0; #1;
    check("minh_u", 64'(inh), 64'h0);
    tick();
    check("minh_read", rdata, 64'h4000_0000_0000_0000);

    // two overflows, clear one at a time
    val[0] = '1; val[5] = '1; inc = 6'b100001;
    tick();
    inc = '0;
    check("two_lcofi", 64'(lcofi), 64'h1);
    we = 1; addr = 12'h323; wdata = '0;
    tick();
    check("one_left_lcofi", 64'(lcofi), 64'h1);
    addr = 12'h328;
    tick();
    we = 0;
    check("none_left_lcofi", 64'(lcofi), 64'h0);

    // asynchronous reset with OF set
    inc[0] = 1; priv = 2'd3;
    tick();
    inc = '0;
    check("pre_rst_lcofi", 64'(lcofi), 64'h1);
    #2;
    rst_n = 0;
    model_reset();
    #1;
    check("async_lcofi", 64'(lcofi), 64'h0);
    check("async_data",  rdata, 64'h0);
    check("async_inh",   64'(inh), 64'h0);
    @(posedge clk); #3;
    rst_n = 1; addr = 12'hDA0;
    tick();
    check("post_rst_scountovf", rdata, 64'h0);

    // randomized traffic
    repeat (600) begin
      r     = $urandom_range(0, 9);
      addr  = (r < 6) ? 12'h323 + 12'(r) : (r == 6) ? 12'hDA0 : (r == 7) ? 12'h723 : 12'($urandom);
      we    = ($urandom_range(0, 2) == 0);
      wdata = {$urandom, $urandom};
      dbg   = ($urandom_range(0, 7) == 0);
      priv  = 2'($urandom_range(0, 3));
      inc   = N'($urandom);
      cwr   = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      for (int i = 0; i < N; i++)
        val[i] = ($urandom_range(0, 1) == 0) ? {64{1'b1}} : {$urandom, $urandom};
      tick();
    end

    idle();
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
